pipe_stall_regs: RTL and testbench
==================================

// Module: pipe_stall_regs
// PURPOSE
//   Front-end pipeline state (PC, IF/ID register, ID/EX control/register-field latch) that consumes
//   the load-use stall outputs PCWr, IFIDWr and hazCtrl, plus a branch-taken flush.
//   Freezes PC and IF/ID, injects a bubble into ID/EX, squashes wrong-path fetch on a branch,
//   and counts stall and flush cycles for performance visibility.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC value loaded on reset
//   CTRL_W     9              width of ID-stage control word latched into ID/EX
//   MEMRD_BIT  3              bit index of MemRead inside the control word
//   CNT_W      16             width of stall/flush performance counters
// PORTS
//   clk           in   1       single clock, all state on rising edge
//   rst_n         in   1       asynchronous reset, active low
//   PCWr          in   1       1 = PC may advance; 0 = hold PC
//   IFIDWr        in   1       1 = IF/ID may load; 0 = hold IF/ID
//   hazCtrl       in   1       1 = insert bubble: zero control word entering ID/EX
//   branchTaken   in   1       branch resolved taken in ID; flush IF/ID, redirect PC
//   branchTarget  in   32      redirect address, valid when branchTaken=1
//   instrIn       in   32      instruction fetched at pcOut
//   idCtrl        in   CTRL_W  decoded control word of instruction in ID
//   idRs,idRt,idRd in  5 each  register fields of instruction in ID
//   pcOut         out  32      current fetch PC
//   IFIDInstr     out  32      IF/ID instruction
//   IFIDPc4       out  32      IF/ID PC+4
//   IDEXCtrl      out  CTRL_W  ID/EX control word
//   IDEXRegRs/Rt/Rd out 5 each ID/EX register fields
//   IDEXMemRead   out  1       IDEXCtrl[MEMRD_BIT]; fed back to hazard detection
//   stallCnt      out  CNT_W   cycles with hazCtrl=1 since reset, saturating
//   flushCnt      out  CNT_W   cycles with branchTaken=1 since reset, saturating
// BEHAVIOUR
//   Reset (rst_n=0, async): pcOut=RESET_PC; IFIDInstr=0 (NOP); IFIDPc4=0; IDEXCtrl=0; IDEXReg*=0;
//     counters=0. Release is synchronous-deasserted by system; first edge after release is normal.
//   PC, per edge, priority order:
//     branchTaken=1 -> pcOut<=branchTarget (overrides PCWr=0)
//     else PCWr=1   -> pcOut<=pcOut+4 (32-bit wrap, 32'hFFFF_FFFC+4 = 0)
//     else hold
//   IF/ID, per edge, priority order:
//     branchTaken=1 -> IFIDInstr<=0, IFIDPc4<=0 (flush to NOP, overrides IFIDWr=0)
//     else IFIDWr=1 -> IFIDInstr<=instrIn, IFIDPc4<=pcOut+4
//     else hold
//   ID/EX, every edge (never held):
//     IDEXRegRs/Rt/Rd <= idRs/idRt/idRd
//     IDEXCtrl <= hazCtrl ? 0 : idCtrl. Bubble has MemRead=0, so a stall never re-triggers itself.
//   Simultaneous branchTaken & hazCtrl: PC and IF/ID follow the flush; ID/EX still bubbles.
//   Net stall latency: one hazCtrl cycle -> same instruction reissued from ID on next cycle,
//     ID/EX sees exactly one zero control word.
//   Counters: +1 on each edge with condition high; hold at all-ones (no wrap).
//   IDEXMemRead is combinational from IDEXCtrl; all other outputs are registered.
//   Reset mid-stall: all state cleared at once; stall input is ignored until rst_n=1.
// TESTING
//   1 reset: rst_n=0 with inputs toggling -> pcOut=RESET_PC, IDEXCtrl=0, counters=0, asynchronously
//   2 free run: PCWr=IFIDWr=1, hazCtrl=0, 4 edges -> pcOut 0,4,8,12,16; IFIDPc4 lags pcOut+4 by one cycle
//   3 load-use: idCtrl=9'h1FF; one cycle PCWr=IFIDWr=0, hazCtrl=1 -> pcOut/IFID held,
//     IDEXCtrl=0, IDEXMemRead=0, stallCnt=1; next cycle IDEXCtrl=9'h1FF
//   4 branch during stall: branchTaken=1, branchTarget=32'h40, PCWr=0, hazCtrl=1 -> pcOut=32'h40,
//     IFIDInstr=0, IDEXCtrl=0, flushCnt=1, stallCnt=1
//   5 wrap/saturate: pcOut=32'hFFFF_FFFC, PCWr=1 -> pcOut=0; force CNT_W=4, 20 stall cycles -> stallCnt=4'hF
//   6 reset mid-operation: assert rst_n=0 between edges during a stall -> outputs clear immediately,
//     then resume from RESET_PC

Source files
------------

// File: rtl/pipe_stall_regs.sv
// Front-end pipeline state: PC, IF/ID and ID/EX latches driven by the load-use stall
// controls and a branch-taken flush, plus saturating stall/flush cycle counters.
module pipe_stall_regs #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CTRL_W    = 9,
    parameter int          MEMRD_BIT = 3,
    parameter int          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PCWr,
    input  logic              IFIDWr,
    input  logic              hazCtrl,
    input  logic              branchTaken,
    input  logic [31:0]       branchTarget,
    input  logic [31:0]       instrIn,
    input  logic [CTRL_W-1:0] idCtrl,
    input  logic [4:0]        idRs,
    input  logic [4:0]        idRt,
    input  logic [4:0]        idRd,
    output logic [31:0]       pcOut,
    output logic [31:0]       IFIDInstr,
    output logic [31:0]       IFIDPc4,
    output logic [CTRL_W-1:0] IDEXCtrl,
    output logic [4:0]        IDEXRegRs,
    output logic [4:0]        IDEXRegRt,
    output logic [4:0]        IDEXRegRd,
    output logic              IDEXMemRead,
    output logic [CNT_W-1:0]  stallCnt,
    output logic [CNT_W-1:0]  flushCnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [31:0]       pc_reg, pc_next;
    logic [31:0]       pc_plus4;
    logic [31:0]       ifid_instr_reg, ifid_instr_next;
    logic [31:0]       ifid_pc4_reg, ifid_pc4_next;
    logic [CTRL_W-1:0] idex_ctrl_reg, idex_ctrl_next;
    logic [4:0]        idex_rs_reg, idex_rt_reg, idex_rd_reg;
    logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;
    logic [CNT_W-1:0]  flush_cnt_reg, flush_cnt_next;

    assign pc_plus4 = pc_reg + 32'd4;

    // A taken branch beats both write-enables: the redirect must land even mid-stall.
    always_comb begin
        pc_next = pc_reg;
        if (branchTaken)
            pc_next = branchTarget;
        else if (PCWr)
            pc_next = pc_plus4;
    end

    always_comb begin
        ifid_instr_next = ifid_instr_reg;
        ifid_pc4_next   = ifid_pc4_reg;
        if (branchTaken) begin
            ifid_instr_next = 32'd0;
            ifid_pc4_next   = 32'd0;
        end else if (IFIDWr) begin
            ifid_instr_next = instrIn;
            ifid_pc4_next   = pc_plus4;
        end
    end

    // Bubble zeroes MemRead too, so hazard detection cannot re-fire on its own bubble.
    always_comb begin
        idex_ctrl_next = hazCtrl ? '0 : idCtrl;
    end

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        flush_cnt_next = flush_cnt_reg;
        if (hazCtrl && (stall_cnt_reg != CNT_MAX))
            stall_cnt_next = stall_cnt_reg + 1'b1;
        if (branchTaken && (flush_cnt_reg != CNT_MAX))
            flush_cnt_next = flush_cnt_reg + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg         <= RESET_PC;
            ifid_instr_reg <= 32'd0;
            ifid_pc4_reg   <= 32'd0;
            idex_ctrl_reg  <= '0;
            idex_rs_reg    <= 5'd0;
            idex_rt_reg    <= 5'd0;
            idex_rd_reg    <= 5'd0;
            stall_cnt_reg  <= '0;
            flush_cnt_reg  <= '0;
        end else begin
            pc_reg         <= pc_next;
            ifid_instr_reg <= ifid_instr_next;
            ifid_pc4_reg   <= ifid_pc4_next;
            idex_ctrl_reg  <= idex_ctrl_next;
            idex_rs_reg    <= idRs;
            idex_rt_reg    <= idRt;
            idex_rd_reg    <= idRd;
            stall_cnt_reg  <= stall_cnt_next;
            flush_cnt_reg  <= flush_cnt_next;
        end
    end

    assign pcOut       = pc_reg;
    assign IFIDInstr   = ifid_instr_reg;
    assign IFIDPc4     = ifid_pc4_reg;
    assign IDEXCtrl    = idex_ctrl_reg;
    assign IDEXRegRs   = idex_rs_reg;
    assign IDEXRegRt   = idex_rt_reg;
    assign IDEXRegRd   = idex_rd_reg;
    assign IDEXMemRead = idex_ctrl_reg[MEMRD_BIT];
    assign stallCnt    = stall_cnt_reg;
    assign flushCnt    = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_stall_regs.sv
// Scoreboard bench for pipe_stall_regs: a behavioural model pushes the expected
// post-edge state when inputs are driven; it is popped and compared after the edge.
module tb_pipe_stall_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PCWr, IFIDWr, hazCtrl, branchTaken;
    logic [31:0] branchTarget, instrIn;
    logic [8:0]  idCtrl;
    logic [4:0]  idRs, idRt, idRd;

    logic [31:0] pcOut, IFIDInstr, IFIDPc4;
    logic [8:0]  IDEXCtrl;
    logic [4:0]  IDEXRegRs, IDEXRegRt, IDEXRegRd;
    logic        IDEXMemRead;
    logic [15:0] stallCnt, flushCnt;

    // narrow-counter instance shares all inputs; only its stall counter is checked
    logic [31:0] s_pc, s_instr, s_pc4;
    logic [8:0]  s_ctrl;
    logic [4:0]  s_rs, s_rt, s_rd;
    logic        s_memrd;
    logic [3:0]  s_stall, s_flush;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stall_regs #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .PCWr(PCWr), .IFIDWr(IFIDWr), .hazCtrl(hazCtrl),
        .branchTaken(branchTaken), .branchTarget(branchTarget), .instrIn(instrIn),
        .idCtrl(idCtrl), .idRs(idRs), .idRt(idRt), .idRd(idRd),
        .pcOut(pcOut), .IFIDInstr(IFIDInstr), .IFIDPc4(IFIDPc4), .IDEXCtrl(IDEXCtrl),
        .IDEXRegRs(IDEXRegRs), .IDEXRegRt(IDEXRegRt), .IDEXRegRd(IDEXRegRd),
        .IDEXMemRead(IDEXMemRead), .stallCnt(stallCnt), .flushCnt(flushCnt)
    );

    pipe_stall_regs #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .PCWr(PCWr), .IFIDWr(IFIDWr), .hazCtrl(hazCtrl),
        .branchTaken(branchTaken), .branchTarget(branchTarget), .instrIn(instrIn),
        .idCtrl(idCtrl), .idRs(idRs), .idRt(idRt), .idRd(idRd),
        .pcOut(s_pc), .IFIDInstr(s_instr), .IFIDPc4(s_pc4), .IDEXCtrl(s_ctrl),
        .IDEXRegRs(s_rs), .IDEXRegRt(s_rt), .IDEXRegRd(s_rd),
        .IDEXMemRead(s_memrd), .stallCnt(s_stall), .flushCnt(s_flush)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [8:0]  ctrl;
        logic [4:0]  rs, rt, rd;
        logic [15:0] stall, flush;
        logic [3:0]  stall4;
    } exp_t;

    exp_t sb[$];
    exp_t m;   // model state

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m.pc = 32'h0; m.instr = 32'h0; m.pc4 = 32'h0; m.ctrl = 9'h0;
        m.rs = 5'h0; m.rt = 5'h0; m.rd = 5'h0;
        m.stall = 16'h0; m.flush = 16'h0; m.stall4 = 4'h0;
    endtask

    task automatic cycle(input logic pcwr, input logic ifidwr, input logic haz,
                         input logic bt, input logic [31:0] tgt, input logic [8:0] ctrl);
        exp_t e, got;
        PCWr = pcwr; IFIDWr = ifidwr; hazCtrl = haz; branchTaken = bt;
        branchTarget = tgt; idCtrl = ctrl; instrIn = $urandom;
        idRs = 5'($urandom); idRt = 5'($urandom); idRd = 5'($urandom);
        e = m;
        if (bt)        e.pc = tgt;
        else if (pcwr) e.pc = m.pc + 32'd4;
        if (bt) begin
            e.instr = 32'h0; e.pc4 = 32'h0;
        end else if (ifidwr) begin
            e.instr = instrIn; e.pc4 = m.pc + 32'd4;
        end
        e.ctrl = haz ? 9'h0 : ctrl;
        e.rs = idRs; e.rt = idRt; e.rd = idRd;
        if (haz && m.stall != 16'hFFFF) e.stall = m.stall + 16'd1;
        if (haz && m.stall4 != 4'hF)    e.stall4 = m.stall4 + 4'd1;
        if (bt && m.flush != 16'hFFFF)  e.flush = m.flush + 16'd1;
        sb.push_back(e);
        m = e;
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("pc",      pcOut,       got.pc);
        check("ifid_in", IFIDInstr,   got.instr);
        check("ifid_p4", IFIDPc4,     got.pc4);
        check("idex_ct", IDEXCtrl,    got.ctrl);
        check("memrd",   IDEXMemRead, got.ctrl[3]);
        check("rs",      IDEXRegRs,   got.rs);
        check("rt",      IDEXRegRt,   got.rt);
        check("rd",      IDEXRegRd,   got.rd);
        check("stall",   stallCnt,    got.stall);
        check("flush",   flushCnt,    got.flush);
        check("stall4",  s_stall,     got.stall4);
        $display("txn pcwr=%b ifidwr=%b haz=%b bt=%b -> pc=%h ifid=%h pc4=%h ctrl=%h st=%0d fl=%0d st4=%0d",
                 pcwr, ifidwr, haz, bt, pcOut, IFIDInstr, IFIDPc4, IDEXCtrl, stallCnt, flushCnt, s_stall);
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"},    pcOut,     32'h0);
        check({tag, "_ifid"},  IFIDInstr, 32'h0);
        check({tag, "_pc4"},   IFIDPc4,   32'h0);
        check({tag, "_ctrl"},  IDEXCtrl,  32'h0);
        check({tag, "_stall"}, stallCnt,  32'h0);
        check({tag, "_flush"}, flushCnt,  32'h0);
        check({tag, "_st4"},   s_stall,   32'h0);
    endtask

    initial begin
        // reset with inputs toggling
        rst_n = 1'b0;
        PCWr = 1'b1; IFIDWr = 1'b1; hazCtrl = 1'b1; branchTaken = 1'b1;
        branchTarget = 32'h1234; instrIn = 32'hDEAD_BEEF; idCtrl = 9'h1FF;
        idRs = 5'd1; idRt = 5'd2; idRd = 5'd3;
        repeat (3) begin
            @(posedge clk); #1;
            hazCtrl = ~hazCtrl; branchTaken = ~branchTaken; instrIn = $urandom;
        end
        check_reset_state("rst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // free run
        repeat (4) cycle(1, 1, 0, 0, 32'h0, 9'($urandom));
        check("free_pc16", pcOut, 32'd16);

        // load-use stall then reissue
        cycle(0, 0, 1, 0, 32'h0, 9'h1FF);
        check("lu_memrd", IDEXMemRead, 1'b0);
        cycle(1, 1, 0, 0, 32'h0, 9'h1FF);
        check("lu_reissue", IDEXCtrl, 9'h1FF);

        // branch during stall
        cycle(0, 0, 1, 1, 32'h40, 9'h1FF);
        check("br_pc", pcOut, 32'h40);
        repeat (2) cycle(1, 1, 0, 0, 32'h0, 9'($urandom));

        // PC wrap
        cycle(0, 1, 0, 1, 32'hFFFF_FFFC, 9'($urandom));
        cycle(1, 1, 0, 0, 32'h0, 9'($urandom));
        check("wrap_pc", pcOut, 32'h0);

        // saturation of the narrow counter
        repeat (20) cycle(0, 0, 1, 0, 32'h0, 9'($urandom));
        check("sat4", s_stall, 4'hF);
        repeat (2) cycle(1, 1, 0, 0, 32'h0, 9'($urandom));

        // reset asserted between edges during a stall
        PCWr = 1'b0; IFIDWr = 1'b0; hazCtrl = 1'b1; branchTaken = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        @(posedge clk); #1;
        check_reset_state("midrst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) cycle(1, 1, 0, 0, 32'h0, 9'($urandom));
        check("resume_pc", pcOut, 32'd16);

        // random mix, including simultaneous branch and bubble
        repeat (40) cycle(1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                          $urandom & 32'hFFFF_FFFC, 9'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
